// File: rtl/pc_next_unit.sv
// Next-PC selection and architectural PC register, with exception entry and return.
// One candidate is picked from src_bus and loaded on pc_write or a taken beq/bne.
module pc_next_unit #(
    parameter int unsigned        WIDTH       = 32,
    parameter int unsigned        NUM_SRC     = 4,
    parameter int unsigned        SEL_W       = 2,
    parameter logic [WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [31:0]        EXC_VECTOR  = 32'h0000_00FF,
    parameter int unsigned        INSTR_BYTES = 4,
    parameter bit                 ALIGN_CHECK = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         pc_source,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     zero,
    input  logic                     branch_ne,
    input  logic                     exc_req,
    input  logic                     eret,
    output logic [WIDTH-1:0]         mux_out,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         epc,
    output logic                     in_exc,
    output logic                     exc_taken,
    output logic                     sel_err,
    output logic                     misalign
);

    typedef enum logic [0:0] {StNormal, StExc} state_e;

    localparam logic [WIDTH-1:0] ExcVec   = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] InstrSz  = WIDTH'(INSTR_BYTES);
    localparam logic [SEL_W:0]   NumSrcW  = (SEL_W + 1)'(NUM_SRC);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             exc_taken_q, exc_taken_d;
    logic             sel_err_q, sel_err_d;
    logic             misalign_q, misalign_d;

    logic load_req;
    logic sel_ok;
    logic tgt_misaligned;

    // Candidate mux; out-of-range selects yield zero.
    always_comb begin
        mux_out = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pc_source == SEL_W'(k)) begin
                mux_out = src_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign load_req       = pc_write | (pc_write_cond & (zero ^ branch_ne));
    assign sel_ok         = {1'b0, pc_source} < NumSrcW;
    assign tgt_misaligned = ALIGN_CHECK && (mux_out[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StNormal;
            pc_q        <= RESET_PC;
            epc_q       <= '0;
            exc_taken_q <= 1'b0;
            sel_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            exc_taken_q <= exc_taken_d;
            sel_err_q   <= sel_err_d;
            misalign_q  <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        exc_taken_d = 1'b0;
        sel_err_d   = 1'b0;
        misalign_d  = 1'b0;
        unique case (state_q)
            StNormal: begin
                if (exc_req) begin
                    epc_d       = pc_q - InstrSz;
                    pc_d        = ExcVec;
                    exc_taken_d = 1'b1;
                    state_d     = StExc;
                end else if (load_req) begin
                    if (!sel_ok) begin
                        sel_err_d = 1'b1;
                    end else if (tgt_misaligned) begin
                        epc_d       = pc_q - InstrSz;
                        pc_d        = ExcVec;
                        misalign_d  = 1'b1;
                        exc_taken_d = 1'b1;
                        state_d     = StExc;
                    end else begin
                        pc_d = mux_out;
                    end
                end
            end
            StExc: begin
                // Handler runs with EPC frozen; a misaligned target only flags, never re-enters.
                if (eret) begin
                    pc_d    = epc_q;
                    state_d = StNormal;
                end else if (load_req) begin
                    if (!sel_ok) begin
                        sel_err_d = 1'b1;
                    end else if (tgt_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = mux_out;
                    end
                end
            end
            default: state_d = StNormal;
        endcase
    end

    always_comb begin
        pc        = pc_q;
        epc       = epc_q;
        in_exc    = (state_q == StExc);
        exc_taken = exc_taken_q;
        sel_err   = sel_err_q;
        misalign  = misalign_q;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the PC-source selector. Selects one of NUM_SRC next-PC candidates and owns the architectural PC register.
- Applies unconditional and conditional (beq/bne) writes and rejects misaligned or out-of-range targets.
- Handles exception entry/return: captures EPC, vectors to the handler, restores on eret.
- Sits between the ALU/ALUOut/jump-target datapath and the instruction-address port; driven by the control FSM.

Parameters:
- WIDTH, 32, datapath / PC width in bits
- NUM_SRC, 4, number of next-PC candidate inputs (2..2**SEL_W)
- SEL_W, 2, width of pc_source select
- RESET_PC, 0, PC value after reset
- EXC_VECTOR, 32'h0000_00FF, handler address loaded on exception entry (truncated to WIDTH)
- INSTR_BYTES, 4, subtracted from PC when forming EPC
- ALIGN_CHECK, 1, 1 = targets with addr[1:0]!=0 raise misalign exception; 0 = no check

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pc_source  in  SEL_W  candidate select
- src_bus  in  NUM_SRC*WIDTH  flattened candidates; slice k = src_bus[k*WIDTH +: WIDTH]
- pc_write  in  1  unconditional PC load
- pc_write_cond  in  1  conditional PC load (branch)
- zero  in  1  ALU zero flag
- branch_ne  in  1  1 = bne (take when zero=0), 0 = beq (take when zero=1)
- exc_req  in  1  external exception request (overflow, bad opcode)
- eret  in  1  return from exception
- mux_out  out  WIDTH  combinational selected candidate (0 if select out of range)
- pc  out  WIDTH  registered PC
- epc  out  WIDTH  registered exception PC
- in_exc  out  1  high while state = EXC
- exc_taken  out  1  one-cycle pulse on exception entry
- sel_err  out  1  one-cycle pulse: load attempted with pc_source >= NUM_SRC
- misalign  out  1  one-cycle pulse: misaligned target trapped

Behaviour:
- Reset (sync, highest priority): pc=RESET_PC, epc=0, state=NORMAL, in_exc=0, all pulses 0. Reset mid-exception discards EPC.
- load_req = pc_write | (pc_write_cond & (zero ^ branch_ne)).
- States: NORMAL, EXC. in_exc = (state==EXC), registered.
- NORMAL, per cycle, in priority order:
  1. exc_req: epc <= pc - INSTR_BYTES (mod 2**WIDTH); pc <= EXC_VECTOR; exc_taken=1; state -> EXC. Any simultaneous load_req or eret is ignored.
  2. load_req with pc_source >= NUM_SRC: pc held; sel_err=1.
  3. load_req with ALIGN_CHECK=1 and target[1:0]!=0: epc <= pc - INSTR_BYTES; pc <= EXC_VECTOR; misalign=1; exc_taken=1; state -> EXC.
  4. load_req otherwise: pc <= target; one-cycle latency (new pc visible the cycle after the request).
  5. eret in NORMAL: ignored.
- EXC:
  - exc_req ignored; no nesting; epc preserved.
  - eret: pc <= epc; state -> NORMAL. eret wins over a simultaneous load_req.
  - load_req without eret: loads normally (handler execution); misaligned target sets misalign=1 and pc holds (no re-entry); out-of-range select sets sel_err=1.
- Pulse outputs are registered and high exactly one cycle after the triggering edge; otherwise 0.
- mux_out is purely combinational from pc_source/src_bus; independent of state.

Test Plan:
- Reset with RESET_PC=0 -> pc=0, epc=0, in_exc=0. pc_write=1, pc_source=0, slice0=0x4 -> pc=0x4 next cycle.
- Branch: pc_write_cond=1, branch_ne=0, zero=0, slice1=0x40 -> pc unchanged. Then zero=1 -> pc=0x40. Then branch_ne=1, zero=0 -> load taken.
- pc=0x100, exc_req=1 together with pc_write=1 -> epc=0xFC, pc=0xFF, exc_taken pulse, in_exc=1. Second exc_req -> epc stays 0xFC.
- In EXC: eret=1 together with pc_write=1 -> pc=0xFC, in_exc=0.
- NUM_SRC=3, pc_source=3, pc_write=1 -> pc held, sel_err pulse, mux_out=0.
- pc=0x20, pc_write with target 0x22 -> epc=0x1C, pc=EXC_VECTOR, misalign+exc_taken pulses. Repeat with ALIGN_CHECK=0 -> pc=0x22.
